// File: rtl/integer_station_scheduler.sv
// Purpose: integer reservation-station pool scheduler. It allocates free stations to dispatch and broadcasts one result per cycle.
// Latency: allocation takes effect at the accepting edge. A result reaches the registered bus one cycle after its station becomes a candidate.
// Backpressure: issue_ready is low when the pool is full or during flush. bus_stall holds candidates in place; nothing is dropped.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   flush                 synchronous squash of every station
//   issue_valid/ready     dispatcher handshake; issue_station is the global tag being allocated
//   occupied              per-station occupied bit
//   result_ready/flat     per-station result strobe and packed result values
//   bus_stall             result-bus slot unavailable this cycle
//   bus_asserted/source/value  registered result-bus slot
module integer_station_scheduler #(
  parameter int SIZE               = 32,
  parameter int STATION_COUNT      = 4,
  parameter int STATION_INDEX_SIZE = 3,
  parameter int STATION_BASE       = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  output logic [STATION_INDEX_SIZE-1:0]   issue_station,
  output logic [STATION_COUNT-1:0]        occupied,
  input  logic [STATION_COUNT-1:0]        result_ready,
  input  logic [SIZE*STATION_COUNT-1:0]   result_flat,
  input  logic                            bus_stall,
  output logic                            bus_asserted,
  output logic [STATION_INDEX_SIZE-1:0]   bus_source,
  output logic [SIZE-1:0]                 bus_value
);

  localparam int PTR_W = $clog2(STATION_COUNT);
  localparam logic [STATION_INDEX_SIZE-1:0] BASE_TAG = STATION_INDEX_SIZE'(STATION_BASE);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(STATION_COUNT - 1);

  logic [PTR_W-1:0]         rr_pointer;
  logic                     free_found;
  logic [PTR_W-1:0]         free_idx;
  logic                     grant_found;
  logic [PTR_W-1:0]         grant_idx;
  logic [STATION_COUNT-1:0] candidates;
  logic                     do_alloc;
  logic                     do_grant;
  logic [STATION_COUNT-1:0] occupied_next;
  logic [PTR_W-1:0]         rr_next;

  // Lowest-index free station. The downward scan lets the smallest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = STATION_COUNT - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        free_found = 1'b1;
        free_idx   = PTR_W'(i);
      end
    end
  end

  assign candidates = occupied & result_ready;

  // Round-robin search starting at rr_pointer. Scanning offsets from high to
  // low leaves the smallest offset, which is the nearest candidate, as the winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = STATION_COUNT - 1; k >= 0; k--) begin
      int j;
      j = (int'(rr_pointer) + k) % STATION_COUNT;
      if (candidates[j]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(j);
      end
    end
  end

  assign issue_ready   = !flush && free_found;
  assign issue_station = BASE_TAG + STATION_INDEX_SIZE'(free_idx);
  assign do_alloc      = issue_valid && issue_ready;
  assign do_grant      = grant_found && !bus_stall && !flush;
  assign rr_next       = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // Allocation only targets free stations and a grant only targets occupied
  // ones, so the set and the clear can never hit the same bit.
  always_comb begin
    occupied_next = occupied;
    if (do_alloc) occupied_next[free_idx]  = 1'b1;
    if (do_grant) occupied_next[grant_idx] = 1'b0;
    if (flush)    occupied_next            = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occupied     <= '0;
      rr_pointer   <= '0;
      bus_asserted <= 1'b0;
      bus_source   <= '0;
      bus_value    <= '0;
    end else begin
      occupied     <= occupied_next;
      bus_asserted <= do_grant;
      if (do_grant) begin
        bus_source <= BASE_TAG + STATION_INDEX_SIZE'(grant_idx);
        bus_value  <= result_flat[grant_idx*SIZE +: SIZE];
        rr_pointer <= rr_next;
      end
    end
  end

endmodule
